// File: rtl/snake_motion_pkg.sv
// Shared types and defaults for the snake motion block.
// - dir_e      : 2-bit joystick direction code (TOP/DOWN/LEFT/RIGHT)
// - SNAKE_*    : grid and body-depth defaults shared with renderer and food logic
// - dir_reverse: opposite direction, used to reject 180-degree turns
package snake_motion_pkg;

    typedef enum logic [1:0] {
        DIR_TOP   = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_e;

    localparam int SNAKE_GRID_W  = 32;
    localparam int SNAKE_GRID_H  = 24;
    localparam int SNAKE_MAX_LEN = 16;

    function automatic dir_e dir_reverse(input dir_e d);
        case (d)
            DIR_TOP:  return DIR_DOWN;
            DIR_DOWN: return DIR_TOP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_motion_if.sv
// Control/status bundle between the game logic (master) and snake_motion (slave).
// master drives: direction, enable, grow, restart, query_x, query_y
// master reads : head_x, head_y, heading, length, move_tick, game_over, hit_body
interface snake_motion_if
    import snake_motion_pkg::*;
#(
    parameter int X_W   = 5,
    parameter int Y_W   = 5,
    parameter int LEN_W = 5
);
    dir_e             direction;
    logic             enable;
    logic             grow;
    logic             restart;
    logic [X_W-1:0]   query_x;
    logic [Y_W-1:0]   query_y;
    logic [X_W-1:0]   head_x;
    logic [Y_W-1:0]   head_y;
    dir_e             heading;
    logic [LEN_W-1:0] length;
    logic             move_tick;
    logic             game_over;
    logic             hit_body;

    modport master (
        output direction, enable, grow, restart, query_x, query_y,
        input  head_x, head_y, heading, length, move_tick, game_over, hit_body
    );

    modport slave (
        input  direction, enable, grow, restart, query_x, query_y,
        output head_x, head_y, heading, length, move_tick, game_over, hit_body
    );
endinterface

// File: rtl/snake_tick_gen.sv
// Movement prescaler: counts 0..TICK_DIV-1 while run_i is high, holds otherwise.
// Ports: clk, rst_n (async, active low), clear_i (sync restart),
//        run_i (enable && !game_over), step_o (combinational step strobe).
module snake_tick_gen #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic run_i,
    output logic step_o
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign step_o = run_i && (count_q == CNT_LAST);

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i) begin
            count_d = step_o ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/snake_motion.sv
// Snake head/body motion on a wrapping grid.
// Ports: clk, rst_n (async, active low), bus (snake_motion_if.slave):
//   inputs  direction, enable, grow, restart, query_x, query_y
//   outputs head_x, head_y, heading, length, move_tick, game_over, hit_body
// seg[0] is the head; seg[i] for i < length are live. A step shifts the body
// and writes the new head, unless the new head lands on a live segment.
module snake_motion
    import snake_motion_pkg::*;
#(
    parameter int GRID_W   = SNAKE_GRID_W,
    parameter int GRID_H   = SNAKE_GRID_H,
    parameter int X_W      = 5,
    parameter int Y_W      = 5,
    parameter int TICK_DIV = 5_000_000,
    parameter int MAX_LEN  = SNAKE_MAX_LEN,
    parameter int INIT_LEN = 3
) (
    input logic           clk,
    input logic           rst_n,
    snake_motion_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam logic [X_W-1:0]   INIT_X   = X_W'(GRID_W / 2);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(GRID_H - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_INIT = LEN_W'(INIT_LEN);

    // Initial body hangs straight down from the grid centre.
    function automatic logic [Y_W-1:0] init_y(input int idx);
        return Y_W'((GRID_H / 2 + idx) % GRID_H);
    endfunction

    logic [X_W-1:0]   seg_x_q [MAX_LEN];
    logic [Y_W-1:0]   seg_y_q [MAX_LEN];
    dir_e             heading_q;
    logic [LEN_W-1:0] length_q;
    logic             grow_pending_q;
    logic             move_tick_q;
    logic             game_over_q;
    logic             hit_body_q;

    logic             step;
    logic             run;
    logic             growing;
    logic             collide;
    logic             advance;
    dir_e             step_heading;
    logic [X_W-1:0]   step_x;
    logic [Y_W-1:0]   step_y;
    logic [MAX_LEN-1:0] body_hit;
    logic [MAX_LEN-1:0] query_hit;

    assign run = bus.enable && !game_over_q;

    snake_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (bus.restart),
        .run_i   (run),
        .step_o  (step)
    );

    // A 180-degree turn request keeps the current heading.
    assign step_heading = (bus.direction == dir_reverse(heading_q)) ? heading_q : bus.direction;

    always_comb begin
        step_x = seg_x_q[0];
        step_y = seg_y_q[0];
        case (step_heading)
            DIR_TOP:   step_y = (seg_y_q[0] == '0)     ? Y_LAST : seg_y_q[0] - Y_W'(1);
            DIR_DOWN:  step_y = (seg_y_q[0] == Y_LAST) ? '0     : seg_y_q[0] + Y_W'(1);
            DIR_LEFT:  step_x = (seg_x_q[0] == '0)     ? X_LAST : seg_x_q[0] - X_W'(1);
            DIR_RIGHT: step_x = (seg_x_q[0] == X_LAST) ? '0     : seg_x_q[0] + X_W'(1);
        endcase
    end

    // A grow at full length is dropped, so the tail still moves away.
    assign growing = (grow_pending_q || bus.grow) && (length_q < LEN_MAX);

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_seg
        logic live;
        logic tail;
        assign live = LEN_W'(gi) < length_q;
        // The tail vacates its cell on this step unless the snake grows.
        assign tail = LEN_W'(gi) == (length_q - LEN_W'(1));
        assign body_hit[gi]  = live && !(tail && !growing)
                               && (seg_x_q[gi] == step_x) && (seg_y_q[gi] == step_y);
        assign query_hit[gi] = live && (seg_x_q[gi] == bus.query_x)
                               && (seg_y_q[gi] == bus.query_y);
    end

    assign collide = |body_hit;
    assign advance = step && !collide && !bus.restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= INIT_X;
                seg_y_q[i] <= init_y(i);
            end
        end else if (bus.restart) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= INIT_X;
                seg_y_q[i] <= init_y(i);
            end
        end else if (advance) begin
            seg_x_q[0] <= step_x;
            seg_y_q[0] <= step_y;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_x_q[i] <= seg_x_q[i-1];
                seg_y_q[i] <= seg_y_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            heading_q      <= DIR_TOP;
            length_q       <= LEN_INIT;
            grow_pending_q <= 1'b0;
            move_tick_q    <= 1'b0;
            game_over_q    <= 1'b0;
            hit_body_q     <= 1'b0;
        end else if (bus.restart) begin
            heading_q      <= DIR_TOP;
            length_q       <= LEN_INIT;
            grow_pending_q <= 1'b0;
            move_tick_q    <= 1'b0;
            game_over_q    <= 1'b0;
            hit_body_q     <= 1'b0;
        end else begin
            hit_body_q  <= |query_hit;
            move_tick_q <= 1'b0;
            if (step) begin
                grow_pending_q <= 1'b0;
                if (collide) begin
                    game_over_q <= 1'b1;
                end else begin
                    heading_q   <= step_heading;
                    move_tick_q <= 1'b1;
                    if (growing) begin
                        length_q <= length_q + LEN_W'(1);
                    end
                end
            end else if (bus.grow) begin
                grow_pending_q <= 1'b1;
            end
        end
    end

    assign bus.head_x    = seg_x_q[0];
    assign bus.head_y    = seg_y_q[0];
    assign bus.heading   = heading_q;
    assign bus.length    = length_q;
    assign bus.move_tick = move_tick_q;
    assign bus.game_over = game_over_q;
    assign bus.hit_body  = hit_body_q;
endmodule
